// File: rtl/vga_pkg.sv
// Shared definitions for the VGA rectangle engine: register field map,
// default 640x480@60 timing and the colour packing helper.
package vga_pkg;

  localparam int unsigned FLD_W    = 3;
  localparam int unsigned COLOUR_W = 8;

  localparam logic [FLD_W-1:0] FLD_X   = 3'd0;
  localparam logic [FLD_W-1:0] FLD_Y   = 3'd1;
  localparam logic [FLD_W-1:0] FLD_W_  = 3'd2;
  localparam logic [FLD_W-1:0] FLD_H   = 3'd3;
  localparam logic [FLD_W-1:0] FLD_COL = 3'd4;
  localparam logic [FLD_W-1:0] FLD_EN  = 3'd5;
  localparam logic [FLD_W-1:0] FLD_BG  = 3'd6;
  localparam logic [FLD_W-1:0] FLD_RSV = 3'd7;

  localparam int unsigned DEF_PIX_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  // Register colour byte is {r3,g3,b2}.
  function automatic rgb_t pack_colour(input logic [COLOUR_W-1:0] raw);
    return rgb_t'(raw);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate timing generator: clock divider, hc/vc raster counters and the
// raw (unregistered) sync, active, vblank and shadow-latch strobes.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            tick_c,
  output logic [HC_W-1:0] hc,
  output logic [VC_W-1:0] vc,
  output logic            hs_c,
  output logic            vs_c,
  output logic            active_c,
  output logic            vblank_c,
  output logic            latch_c
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [VC_W-1:0]  vc_q, vc_d;

  assign tick_c = (div_q == DIV_W'(PIX_DIV - 1));
  assign hc     = hc_q;
  assign vc     = vc_q;

  always_comb begin
    div_d = div_q;
    hc_d  = hc_q;
    vc_d  = vc_q;
    if (tick_c) begin
      div_d = '0;
      if (hc_q == HC_W'(H_TOTAL - 1)) begin
        hc_d = '0;
        vc_d = (vc_q == VC_W'(V_TOTAL - 1)) ? '0 : vc_q + VC_W'(1);
      end else begin
        hc_d = hc_q + HC_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      hc_q  <= '0;
      vc_q  <= '0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      vc_q  <= vc_d;
    end
  end

  assign hs_c     = (hc_q >= HC_W'(H_ACTIVE + H_FP)) && (hc_q < HC_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_c     = (vc_q >= VC_W'(V_ACTIVE + V_FP)) && (vc_q < VC_W'(V_ACTIVE + V_FP + V_SYNC));
  assign active_c = (hc_q < HC_W'(H_ACTIVE)) && (vc_q < VC_W'(V_ACTIVE));
  assign vblank_c = (vc_q >= VC_W'(V_ACTIVE));

  // Tick on which the counters step to (hc=0, vc=V_ACTIVE).
  assign latch_c  = tick_c && (hc_q == HC_W'(H_TOTAL - 1)) && (vc_q == VC_W'(V_ACTIVE - 1));

endmodule

// File: rtl/vga_rect_engine.sv
// VGA display engine: bus-written shadow registers copied to the active set
// at vertical blank, N_RECT priority-ordered rectangle hit tests, output regs.
module vga_rect_engine
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV  = DEF_PIX_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned N_RECT   = 4,
  parameter int unsigned COORD_W  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic [$clog2(N_RECT)+2:0]  addr,
  input  logic [COORD_W-1:0]         data_in,
  output logic                       HS,
  output logic                       VS,
  output logic [2:0]                 red,
  output logic [2:0]                 green,
  output logic [1:0]                 blue,
  output logic                       vblank
);

  localparam int unsigned AW   = $clog2(N_RECT) + 3;
  localparam int unsigned HC_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VC_W = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned CW1  = COORD_W + 1;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COORD_W-1:0]  w;
    logic [COORD_W-1:0]  h;
    logic [COLOUR_W-1:0] colour;
    logic                en;
  } rect_t;

  logic            tick_c, hs_c, vs_c, active_c, vblank_c, latch_c;
  logic [HC_W-1:0] hc;
  logic [VC_W-1:0] vc;

  vga_timing #(
    .PIX_DIV (PIX_DIV),  .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HC_W(HC_W), .VC_W(VC_W)
  ) u_timing (
    .clk(clk), .rst(rst), .tick_c(tick_c), .hc(hc), .vc(vc), .hs_c(hs_c), .vs_c(vs_c),
    .active_c(active_c), .vblank_c(vblank_c), .latch_c(latch_c)
  );

  logic [AW-1:0]    wr_idx_c;
  logic [FLD_W-1:0] wr_fld_c;
  logic [CW1-1:0]   hc_ext, vc_ext;

  assign wr_idx_c = addr >> FLD_W;
  assign wr_fld_c = addr[FLD_W-1:0];
  assign hc_ext   = CW1'(hc);
  assign vc_ext   = CW1'(vc);

  logic [N_RECT-1:0]          hit_c;
  logic [N_RECT*COLOUR_W-1:0] colours_c;

  for (genvar g = 0; g < N_RECT; g++) begin : g_rect
    rect_t          shadow_q, shadow_d, active_q, active_d;
    logic [CW1-1:0] x_lo, x_hi, y_lo, y_hi;

    always_comb begin
      shadow_d = shadow_q;
      if (sel && (wr_idx_c == AW'(g))) begin
        case (wr_fld_c)
          FLD_X:   shadow_d.x      = data_in;
          FLD_Y:   shadow_d.y      = data_in;
          FLD_W_:  shadow_d.w      = data_in;
          FLD_H:   shadow_d.h      = data_in;
          FLD_COL: shadow_d.colour = COLOUR_W'(data_in);
          FLD_EN:  shadow_d.en     = data_in[0];
          FLD_BG, FLD_RSV: ;
          default: ;
        endcase
      end
      // The copy takes pre-edge shadow, so a same-clk write waits a frame.
      active_d = latch_c ? shadow_q : active_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end

    // Extra bit on the far edges keeps x+w and y+h from wrapping.
    assign x_lo = CW1'(active_q.x);
    assign x_hi = x_lo + CW1'(active_q.w);
    assign y_lo = CW1'(active_q.y);
    assign y_hi = y_lo + CW1'(active_q.h);

    assign hit_c[g] = active_q.en && (hc_ext >= x_lo) && (hc_ext < x_hi)
                                  && (vc_ext >= y_lo) && (vc_ext < y_hi);
    assign colours_c[g*COLOUR_W +: COLOUR_W] = active_q.colour;
  end

  logic [COLOUR_W-1:0] bg_sh_q, bg_sh_d, bg_act_q, bg_act_d;

  always_comb begin
    bg_sh_d  = bg_sh_q;
    bg_act_d = latch_c ? bg_sh_q : bg_act_q;
    if (sel && (wr_idx_c == '0) && (wr_fld_c == FLD_BG)) begin
      bg_sh_d = COLOUR_W'(data_in);
    end
  end

  // Lowest hit index wins: scan from the top so lower indices overwrite.
  logic [COLOUR_W-1:0] pix_c;
  logic [N_RECT-1:0]   hit_sh;

  always_comb begin
    pix_c  = bg_act_q;
    hit_sh = '0;
    for (int i = N_RECT - 1; i >= 0; i--) begin
      hit_sh = hit_c >> i;
      if (hit_sh[0]) begin
        pix_c = COLOUR_W'(colours_c >> (i * COLOUR_W));
      end
    end
  end

  logic hs_q, hs_d, vs_q, vs_d, vblank_q, vblank_d;
  rgb_t rgb_q, rgb_d;

  always_comb begin
    hs_d     = hs_q;
    vs_d     = vs_q;
    vblank_d = vblank_q;
    rgb_d    = rgb_q;
    if (tick_c) begin
      hs_d     = hs_c ? HS_POL : ~HS_POL;
      vs_d     = vs_c ? VS_POL : ~VS_POL;
      vblank_d = vblank_c;
      rgb_d    = active_c ? pack_colour(pix_c) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bg_sh_q  <= '0;
      bg_act_q <= '0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      vblank_q <= 1'b0;
      rgb_q    <= '0;
    end else begin
      bg_sh_q  <= bg_sh_d;
      bg_act_q <= bg_act_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      vblank_q <= vblank_d;
      rgb_q    <= rgb_d;
    end
  end

  assign HS     = hs_q;
  assign VS     = vs_q;
  assign vblank = vblank_q;
  assign red    = rgb_q.r;
  assign green  = rgb_q.g;
  assign blue   = rgb_q.b;

endmodule
